// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the 5-stage MIPS core.
// It handles load-use stalls (optionally multi-cycle), taken-branch flushes
// and data-memory wait freezes. It also counts stalled cycles with a
// saturating counter. Outputs are Mealy: a function of state and current inputs.
module hazard_controller #(
    parameter int AWIDTH    = 5,
    parameter int LU_CYCLES = 1,
    parameter int CWIDTH    = 16
) (
    input  logic              hz_clk,
    input  logic              hz_rst,
    input  logic              hz_i_ce,
    input  logic [AWIDTH-1:0] hz_i_id_rs,
    input  logic [AWIDTH-1:0] hz_i_id_rt,
    input  logic              hz_i_id_uses_rt,
    input  logic              hz_i_ex_memread,
    input  logic [AWIDTH-1:0] hz_i_ex_rd,
    input  logic              hz_i_branch_taken,
    input  logic              hz_i_mem_busy,
    output logic              hz_o_pc_we,
    output logic              hz_o_ifid_we,
    output logic              hz_o_ifid_flush,
    output logic              hz_o_idex_we,
    output logic              hz_o_idex_bubble,
    output logic              hz_o_exmem_we,
    output logic [1:0]        hz_o_state,
    output logic [CWIDTH-1:0] hz_o_stall_cnt
);

    // Remaining stall cycles after the current one never exceed LU_CYCLES-1.
    localparam int NW = (LU_CYCLES > 1) ? $clog2(LU_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    state_t          ret_reg, ret_next;
    state_t          eff_state;
    logic [NW-1:0]   cnt_reg, cnt_next;
    logic [CWIDTH-1:0] stall_cnt_reg;
    logic            lu;

    assign lu = hz_i_ex_memread && (hz_i_ex_rd != '0) &&
                ((hz_i_ex_rd == hz_i_id_rs) ||
                 (hz_i_id_uses_rt && (hz_i_ex_rd == hz_i_id_rt)));

    // Leaving MEM_WAIT behaves exactly like the saved state in the same cycle.
    assign eff_state = (state_reg == MEM_WAIT && !hz_i_mem_busy) ? ret_reg : state_reg;

    // Next-state and control outputs; priority ce, mem_busy, branch, load-use.
    always_comb begin
        hz_o_pc_we       = 1'b0;
        hz_o_ifid_we     = 1'b0;
        hz_o_ifid_flush  = 1'b0;
        hz_o_idex_we     = 1'b0;
        hz_o_idex_bubble = 1'b0;
        hz_o_exmem_we    = 1'b0;
        state_next       = state_reg;
        ret_next         = ret_reg;
        cnt_next         = cnt_reg;
        if (!hz_rst && hz_i_ce) begin
            if (hz_i_mem_busy) begin
                // Freeze everything; remember where to resume.
                if (state_reg != MEM_WAIT)
                    ret_next = state_reg;
                state_next = MEM_WAIT;
            end else if (hz_i_branch_taken) begin
                // Squash the wrong-path instructions; any pending stall is dropped.
                hz_o_pc_we       = 1'b1;
                hz_o_ifid_we     = 1'b1;
                hz_o_ifid_flush  = 1'b1;
                hz_o_idex_we     = 1'b1;
                hz_o_idex_bubble = 1'b1;
                hz_o_exmem_we    = 1'b1;
                state_next       = RUN;
                cnt_next         = '0;
            end else if (eff_state == LU_STALL) begin
                hz_o_idex_we     = 1'b1;
                hz_o_idex_bubble = 1'b1;
                hz_o_exmem_we    = 1'b1;
                if (cnt_reg <= NW'(1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    state_next = LU_STALL;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end else if (lu) begin
                // Hold PC and IF/ID, push a bubble behind the load.
                hz_o_idex_we     = 1'b1;
                hz_o_idex_bubble = 1'b1;
                hz_o_exmem_we    = 1'b1;
                if (LU_CYCLES > 1) begin
                    state_next = LU_STALL;
                    cnt_next   = NW'(LU_CYCLES - 1);
                end else begin
                    state_next = RUN;
                end
            end else begin
                hz_o_pc_we    = 1'b1;
                hz_o_ifid_we  = 1'b1;
                hz_o_idex_we  = 1'b1;
                hz_o_exmem_we = 1'b1;
                state_next    = RUN;
            end
        end
    end

    // State, resume state and stall-length counter registers.
    always_ff @(posedge hz_clk or posedge hz_rst) begin
        if (hz_rst) begin
            state_reg <= RUN;
            ret_reg   <= RUN;
            cnt_reg   <= '0;
        end else if (hz_i_ce) begin
            state_reg <= state_next;
            ret_reg   <= ret_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Saturating count of cycles in which the PC was held while enabled.
    always_ff @(posedge hz_clk or posedge hz_rst) begin
        if (hz_rst)
            stall_cnt_reg <= '0;
        else if (hz_i_ce && !hz_o_pc_we && stall_cnt_reg != {CWIDTH{1'b1}})
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end

    assign hz_o_state     = state_reg;
    assign hz_o_stall_cnt = stall_cnt_reg;

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the decoder stage and watches the ID instruction's source registers, the EX-stage load, the branch resolution and the data-memory busy flag. It generates write-enable, flush and bubble controls for PC, IF/ID, ID/EX and EX/MEM. It covers load-use stalls (multi-cycle via counter), branch flushes and memory-wait freezes, and keeps a stall-cycle performance counter.

Parameters:
AWIDTH, 5, register address width
LU_CYCLES, 1, load-use stall length in cycles (>=1)
CWIDTH, 16, stall performance counter width

Ports:
hz_clk  input  1  clock, rising edge
hz_rst  input  1  reset, asynchronous, active-high
hz_i_ce  input  1  pipeline enable; 0 freezes all stages
hz_i_id_rs  input  AWIDTH  rs of instruction in ID
hz_i_id_rt  input  AWIDTH  rt of instruction in ID
hz_i_id_uses_rt  input  1  ID instruction reads rt (R-type, branch, store)
hz_i_ex_memread  input  1  instruction in EX is a load
hz_i_ex_rd  input  AWIDTH  destination register of EX instruction
hz_i_branch_taken  input  1  branch resolved taken in EX
hz_i_mem_busy  input  1  data memory not ready
hz_o_pc_we  output  1  PC write enable
hz_o_ifid_we  output  1  IF/ID write enable
hz_o_ifid_flush  output  1  clear IF/ID to NOP
hz_o_idex_we  output  1  ID/EX write enable
hz_o_idex_bubble  output  1  load NOP/zero controls into ID/EX
hz_o_exmem_we  output  1  EX/MEM write enable
hz_o_state  output  2  FSM state: RUN=0, LU_STALL=1, MEM_WAIT=2
hz_o_stall_cnt  output  CWIDTH  stall cycles counted

Behaviour:
- Reset (hz_rst=1, any time, immediate):
  - state=RUN, internal counter=0, saved return state=RUN, hz_o_stall_cnt=0.
  - All enables, flush and bubble outputs are 0 while reset is asserted.
- Outputs are combinational (Mealy) from state plus current inputs. State and counters update on the rising edge of hz_clk.
- Load-use hazard lu = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- Input priority in every state: ce=0 first, then mem_busy, then branch_taken, then lu.
- ce=0 (any state): all enables, flush and bubble are 0. State, counters and stall_cnt hold.
- RUN:
  - mem_busy: all four WEs 0, no flush or bubble. Save return=RUN; next state MEM_WAIT.
  - branch_taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_we=1, idex_bubble=1, exmem_we=1. Stay RUN. Any lu in the same cycle is discarded.
  - lu: pc_we=0, ifid_we=0, idex_we=1, idex_bubble=1, exmem_we=1.
    - LU_CYCLES=1: stay RUN.
    - LU_CYCLES>1: cnt=LU_CYCLES-1, next state LU_STALL.
  - none of the above: all WEs 1, flush and bubble 0.
- LU_STALL:
  - Default outputs are the same as the lu case. cnt decrements each cycle; when cnt==1, the next state is RUN.
  - mem_busy: freeze all WEs, cnt holds. Save return=LU_STALL; next state MEM_WAIT.
  - branch_taken: branch outputs as in RUN. Stall aborted, cnt=0, next state RUN.
- MEM_WAIT:
  - mem_busy=1: all WEs 0. Stay in MEM_WAIT.
  - mem_busy=0: that same cycle, outputs and next state are exactly those of the saved return state evaluated with current inputs (no extra dead cycle).
- hz_o_stall_cnt:
  - Increments by 1 on each cycle with reset low, ce=1 and pc_we=0.
  - Saturates at all-ones; no wrap-around.

Test Plan:
- Reset, then ce=1, no hazards:
  - hz_rst=1 -> all outputs 0, state 0, stall_cnt 0.
  - After release -> pc_we=ifid_we=idex_we=exmem_we=1, flush=0, bubble=0.
- LU_CYCLES=1, ex_memread=1, ex_rd=2, id_rs=2 for 1 cycle:
  - That cycle: pc_we=0, ifid_we=0, idex_bubble=1.
  - Next cycle (inputs cleared): all WEs 1; stall_cnt=1.
- No false hazards:
  - ex_rd=0 with id_rs=0 and memread=1 -> no stall.
  - id_uses_rt=0 with ex_rd=id_rt=5 -> no stall.
  - id_uses_rt=1 -> stall.
- LU_CYCLES=3, lu for 1 cycle:
  - 3 consecutive cycles with pc_we=0; hz_o_state=1 for cycles 2-3, then 0.
  - stall_cnt=3.
- mem_busy=1 for 3 cycles starting in cycle 2 of LU_STALL (LU_CYCLES=3):
  - state=2 and all WEs 0 for 3 cycles.
  - On the release cycle the remaining stall cycle is applied; stall_cnt=6 at end.
- Priority and reset mid-operation:
  - branch_taken=1 together with lu -> pc_we=1, ifid_flush=1, idex_bubble=1, state 0.
  - hz_rst pulsed mid-LU_STALL -> state 0 and stall_cnt 0 immediately, without waiting for a clock edge.
